// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: fixed-priority arbiter and sequencer for the shared memory address port
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  req,
    input  logic [4:0]  wr,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  IorD,
    output logic        mem_wr,
    output logic [4:0]  grant,
    output logic        done,
    output logic [31:0] rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd1 : 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  grant_q, grant_d;
    logic [2:0]  iord_q, iord_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  win;

    // Fixed priority winner: 1 > 3 > 2 > 4 > 0
    always_comb begin
        win = 3'd0;
        if (req[1]) win = 3'd1;
        else if (req[3]) win = 3'd3;
        else if (req[2]) win = 3'd2;
        else if (req[4]) win = 3'd4;
    end

    // Next-state logic: grant in IDLE, count read latency, release after DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        iord_d  = iord_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (|req) begin
                grant_d = 5'b1 << win;
                iord_d  = win;
                state_d = wr[win] ? WRITE : READ;
                cnt_d   = wr[win] ? cnt_q : CNT_INIT;
            end
            READ: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end
            end
            WRITE: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                grant_d = 5'b0;
                iord_d  = 3'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            grant_q <= 5'b0;
            iord_q  <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            iord_q  <= iord_d;
            rdata_q <= rdata_d;
        end
    end

    assign IorD   = iord_q;
    assign grant  = grant_q;
    assign rdata  = rdata_q;
    assign mem_wr = (state_q == WRITE);
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized transaction-level check of mem_access_ctrl
module tb_mem_access_ctrl;
    localparam int W = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  req, wr;
    logic [31:0] mem_rdata;
    logic [2:0]  IorD;
    logic        mem_wr, done, busy;
    logic [4:0]  grant;
    logic [31:0] rdata;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = 32'd0;

    mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .mem_rdata(mem_rdata),
        .IorD(IorD), .mem_wr(mem_wr), .grant(grant), .done(done), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [4:0] r);
        int order[5] = '{1, 3, 2, 4, 0};
        for (int k = 0; k < 5; k++)
            if (r[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_iord"}, IorD, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    // One whole transaction from IDLE, ending after the following IDLE cycle
    task automatic run_txn(input logic [4:0] r, input logic [4:0] w, input bit noise);
        int          win, n;
        bit          is_wr;
        logic [31:0] last;
        win   = pick(r);
        is_wr = w[win];
        req   = r;
        wr    = w;
        last  = exp_rdata;
        cyc();
        n = is_wr ? 1 : W;
        for (int i = 0; i < n; i++) begin
            chk("busy", busy, 1);
            chk("grant", grant, 32'(1 << win));
            chk("iord", IorD, win);
            chk("mem_wr", mem_wr, is_wr);
            chk("done_early", done, 0);
            if (noise) begin
                req = r | 5'b00010 | 5'($urandom);
                wr  = ~wr;
            end
            mem_rdata = $urandom;
            last = mem_rdata;
            cyc();
        end
        if (!is_wr) exp_rdata = last;
        chk("done", done, 1);
        chk("done_busy", busy, 1);
        chk("done_grant", grant, 32'(1 << win));
        chk("done_iord", IorD, win);
        chk("done_mem_wr", mem_wr, 0);
        chk("rdata", rdata, exp_rdata);
        req = r & ~(5'b1 << win);
        wr  = 5'b0;
        cyc();
        chk_idle("gap");
    endtask

    initial begin
        logic [4:0] m;
        reset = 1'b1;
        req = 5'b11111;
        wr = 5'b0;
        mem_rdata = 32'd0;
        cyc();
        chk_idle("rst1");
        cyc();
        chk_idle("rst2");
        reset = 1'b0;
        req = 5'b0;
        cyc();
        chk_idle("post_rst");

        run_txn(5'b00001, 5'b00000, 0);
        run_txn(5'b01000, 5'b01000, 0);

        m = 5'b11111;
        while (m != 5'b0) begin
            run_txn(m, 5'b00000, 0);
            m = m & ~(5'b1 << pick(m));
        end

        run_txn(5'b10000, 5'b00000, 1);
        run_txn(5'b00010, 5'b00000, 0);

        for (int t = 0; t < 40; t++)
            run_txn(5'($urandom_range(1, 31)), 5'($urandom), t[0]);

        run_txn(5'b00001, 5'b00000, 0);
        req = 5'b00001;
        wr = 5'b0;
        cyc();
        chk("abort_read1", busy, 1);
        mem_rdata = $urandom;
        cyc();
        chk("abort_read2", busy, 1);
        reset = 1'b1;
        cyc();
        exp_rdata = 32'd0;
        chk_idle("abort_rd");
        reset = 1'b0;
        req = 5'b0;
        cyc();
        chk_idle("abort_rd_after");

        req = 5'b00100;
        wr = 5'b00100;
        cyc();
        chk("abort_wr_mem_wr", mem_wr, 1);
        reset = 1'b1;
        cyc();
        chk_idle("abort_wr");
        reset = 1'b0;
        req = 5'b0;
        wr = 5'b0;
        cyc();
        chk_idle("abort_wr_after");

        run_txn(5'b00001, 5'b00000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
